// File: rtl/bus_xfer_engine.sv
// bus_xfer_engine: parametrised register file on a shared tri-state bus.
// Executes LOAD/MOVE in one bus cycle and SWAP in three bus cycles through TMP.
module bus_xfer_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 4,
  parameter int unsigned AW    = 4
) (
  input  logic                   Clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [1:0]             cmd_op,
  input  logic [AW-1:0]          cmd_src,
  input  logic [AW-1:0]          cmd_dst,
  input  logic [WIDTH-1:0]       Data,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output wire  [WIDTH-1:0]       bus,
  output logic [NREGS*WIDTH-1:0] Q
);

  typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_MOVE, OP_SWAP} op_e;
  typedef enum logic [2:0] {S_IDLE, S_XFER, S_SW1, S_SW2, S_SW3} state_e;

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              accept;
  op_e               op_q;
  logic [AW-1:0]     src_q, dst_q;
  logic [WIDTH-1:0]  data_q;
  logic [WIDTH-1:0]  tmp_q;
  logic [WIDTH-1:0]  regs_q [NREGS];

  // Per-driver enables and per-target write strobes
  logic [NREGS-1:0]  reg_oe, reg_we;
  logic              data_oe, tmp_oe, tmp_we;
  logic [WIDTH-1:0]  bus_val;
  logic              any_oe;
  logic              dst_bad, src_bad, same_idx;

  assign dst_bad  = 32'(cmd_dst) >= NREGS;
  assign src_bad  = 32'(cmd_src) >= NREGS;
  assign same_idx = (cmd_src == cmd_dst);

  // Next-state, bus driver enables and write strobes
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    accept  = 1'b0;
    reg_oe  = '0;
    reg_we  = '0;
    data_oe = 1'b0;
    tmp_oe  = 1'b0;
    tmp_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              if (dst_bad) begin
                err_d = 1'b1;
              end else begin
                accept  = 1'b1;
                state_d = S_XFER;
              end
            end
            OP_MOVE, OP_SWAP: begin
              if (dst_bad || src_bad || same_idx) begin
                err_d = 1'b1;
              end else begin
                accept  = 1'b1;
                state_d = (cmd_op == OP_SWAP) ? S_SW1 : S_XFER;
              end
            end
            default: ;
          endcase
        end
      end
      S_XFER: begin
        data_oe = (op_q == OP_LOAD);
        for (int unsigned i = 0; i < NREGS; i++) begin
          reg_oe[i] = (op_q == OP_MOVE) && (src_q == AW'(i));
          reg_we[i] = (dst_q == AW'(i));
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_SW1: begin
        for (int unsigned i = 0; i < NREGS; i++) reg_oe[i] = (src_q == AW'(i));
        tmp_we  = 1'b1;
        state_d = S_SW2;
      end
      S_SW2: begin
        for (int unsigned i = 0; i < NREGS; i++) begin
          reg_oe[i] = (dst_q == AW'(i));
          reg_we[i] = (src_q == AW'(i));
        end
        state_d = S_SW3;
      end
      S_SW3: begin
        tmp_oe = 1'b1;
        for (int unsigned i = 0; i < NREGS; i++) reg_we[i] = (dst_q == AW'(i));
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One-hot enables select the single active driver's value
  always_comb begin
    bus_val = '0;
    if (data_oe) bus_val = bus_val | data_q;
    if (tmp_oe)  bus_val = bus_val | tmp_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (reg_oe[i]) bus_val = bus_val | regs_q[i];
    end
  end

  assign any_oe = data_oe | tmp_oe | (|reg_oe);
  assign bus    = any_oe ? bus_val : {WIDTH{1'bz}};

  // State register and status pulses
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Command latch, register file and TMP
  always_ff @(posedge Clock) begin
    if (reset) begin
      op_q   <= OP_NOP;
      src_q  <= '0;
      dst_q  <= '0;
      data_q <= '0;
      tmp_q  <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_e'(cmd_op);
        src_q  <= cmd_src;
        dst_q  <= cmd_dst;
        data_q <= Data;
      end
      if (tmp_we) tmp_q <= bus_val;
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (reg_we[i]) regs_q[i] <= bus_val;
      end
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign err  = err_q;

  // Flatten register file onto Q
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) Q[i*WIDTH +: WIDTH] = regs_q[i];
  end

endmodule

// File: tb/tb_bus_xfer_engine.sv
// Directed bench for bus_xfer_engine: vector table plus multi-cycle sequences.
module tb_bus_xfer_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_src, cmd_dst;
  logic [7:0]  Data;
  logic        busy, done, err;
  wire  [7:0]  bus_w;
  logic [31:0] Q;

  logic         cmd_valid2;
  logic [1:0]   cmd_op2;
  logic [3:0]   cmd_src2, cmd_dst2;
  logic [15:0]  Data2;
  logic         busy2, done2, err2;
  wire  [15:0]  bus2_w;
  logic [127:0] Q2;

  int total = 0;
  int bad   = 0;

  // Undriven bus reads as all ones through weak pull-ups
  for (genvar i = 0; i < 8; i++) begin : g_pu1
    pullup pu (bus_w[i]);
  end
  for (genvar i = 0; i < 16; i++) begin : g_pu2
    pullup pu (bus2_w[i]);
  end

  always #5 clk = ~clk;

  bus_xfer_engine #(.WIDTH(8), .NREGS(4), .AW(4)) dut (
    .Clock(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .Data(Data), .busy(busy),
    .done(done), .err(err), .bus(bus_w), .Q(Q)
  );

  bus_xfer_engine #(.WIDTH(16), .NREGS(8), .AW(4)) dut16 (
    .Clock(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_op(cmd_op2),
    .cmd_src(cmd_src2), .cmd_dst(cmd_dst2), .Data(Data2), .busy(busy2),
    .done(done2), .err(err2), .bus(bus2_w), .Q(Q2)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [7:0]  data;
    logic        e;
    int          cyc;
    logic [7:0]  b0, b1, b2;
    logic [31:0] q;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [7:0] seen [3];
    int n;

    vecs[0] = '{2'd1, 4'd0, 4'd0, 8'h01, 1'b0, 1, 8'h01, 8'h00, 8'h00, 32'h00000001};
    vecs[1] = '{2'd1, 4'd0, 4'd1, 8'h02, 1'b0, 1, 8'h02, 8'h00, 8'h00, 32'h00000201};
    vecs[2] = '{2'd1, 4'd9, 4'd2, 8'h03, 1'b0, 1, 8'h03, 8'h00, 8'h00, 32'h00030201};
    vecs[3] = '{2'd1, 4'd0, 4'd3, 8'h04, 1'b0, 1, 8'h04, 8'h00, 8'h00, 32'h04030201};
    vecs[4] = '{2'd0, 4'd1, 4'd2, 8'h77, 1'b0, 0, 8'h00, 8'h00, 8'h00, 32'h04030201};
    vecs[5] = '{2'd2, 4'd2, 4'd0, 8'h99, 1'b0, 1, 8'h03, 8'h00, 8'h00, 32'h04030203};
    vecs[6] = '{2'd2, 4'd1, 4'd1, 8'h00, 1'b1, 0, 8'h00, 8'h00, 8'h00, 32'h04030203};
    vecs[7] = '{2'd1, 4'd0, 4'd4, 8'h55, 1'b1, 0, 8'h00, 8'h00, 8'h00, 32'h04030203};
    vecs[8] = '{2'd3, 4'd5, 4'd0, 8'h00, 1'b1, 0, 8'h00, 8'h00, 8'h00, 32'h04030203};
    vecs[9] = '{2'd3, 4'd1, 4'd3, 8'h00, 1'b0, 3, 8'h02, 8'h04, 8'h02, 32'h02030403};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_src = '0; cmd_dst = '0; Data = '0;
    cmd_valid2 = 1'b0; cmd_op2 = 2'd0; cmd_src2 = '0; cmd_dst2 = '0; Data2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_q", Q, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_bus", bus_w, 8'hFF);
    chk("rst_q16", Q2, 128'h0);
    reset = 1'b0;
    @(negedge clk);

    // Table of single commands
    for (int v = 0; v < 10; v++) begin
      cmd_valid = 1'b1; cmd_op = vecs[v].op; cmd_src = vecs[v].src;
      cmd_dst = vecs[v].dst; Data = vecs[v].data;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (vecs[v].e) begin
        chk($sformatf("v%0d_err", v), err, 1'b1);
        chk($sformatf("v%0d_busy", v), busy, 1'b0);
        chk($sformatf("v%0d_q", v), Q, vecs[v].q);
        @(negedge clk);
        chk($sformatf("v%0d_err_end", v), err, 1'b0);
      end else if (vecs[v].cyc == 0) begin
        chk($sformatf("v%0d_busy", v), busy, 1'b0);
        chk($sformatf("v%0d_err", v), err, 1'b0);
        @(negedge clk);
        chk($sformatf("v%0d_done", v), done, 1'b0);
        chk($sformatf("v%0d_q", v), Q, vecs[v].q);
      end else begin
        n = 0;
        while (busy === 1'b1 && n < 8) begin
          if (n < 3) seen[n] = bus_w;
          n++;
          @(negedge clk);
        end
        chk($sformatf("v%0d_cycles", v), n, vecs[v].cyc);
        chk($sformatf("v%0d_bus0", v), seen[0], vecs[v].b0);
        if (vecs[v].cyc == 3) begin
          chk($sformatf("v%0d_bus1", v), seen[1], vecs[v].b1);
          chk($sformatf("v%0d_bus2", v), seen[2], vecs[v].b2);
        end
        chk($sformatf("v%0d_done", v), done, 1'b1);
        chk($sformatf("v%0d_err", v), err, 1'b0);
        chk($sformatf("v%0d_q", v), Q, vecs[v].q);
        @(negedge clk);
        chk($sformatf("v%0d_done_end", v), done, 1'b0);
        chk($sformatf("v%0d_bus_idle", v), bus_w, 8'hFF);
      end
    end

    // MOVE with inputs changing while it executes
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_src = 4'd1; cmd_dst = 4'd2; Data = 8'h55;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'd1; cmd_src = 4'd3; Data = 8'hAA;
    chk("mv_busy", busy, 1'b1);
    chk("mv_bus", bus_w, 8'h04);
    @(negedge clk);
    chk("mv_done", done, 1'b1);
    chk("mv_q", Q, 32'h02040403);
    @(negedge clk);

    // MOVE held valid throughout a SWAP
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_src = 4'd0; cmd_dst = 4'd3;
    @(negedge clk);
    cmd_op = 2'd2; cmd_src = 4'd0; cmd_dst = 4'd1;
    n = 0;
    while (busy === 1'b1 && n < 8) begin
      n++;
      @(negedge clk);
    end
    chk("hs_cycles", n, 3);
    chk("hs_done", done, 1'b1);
    chk("hs_busy_done", busy, 1'b0);
    chk("hs_q_swap", Q, 32'h03040402);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hs_mv_busy", busy, 1'b1);
    chk("hs_mv_bus", bus_w, 8'h02);
    @(negedge clk);
    chk("hs_mv_done", done, 1'b1);
    chk("hs_mv_q", Q, 32'h03040202);
    @(negedge clk);

    // Reset asserted in the middle of a SWAP
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_src = 4'd1; cmd_dst = 4'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rs_busy_pre", busy, 1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rs_q", Q, 32'h0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_done", done, 1'b0);
    chk("rs_bus", bus_w, 8'hFF);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rs_q_after", Q, 32'h0);
    chk("rs_done_after", done, 1'b0);
    chk("rs_busy_after", busy, 1'b0);

    // Wide instance: load into the top register
    cmd_valid2 = 1'b1; cmd_op2 = 2'd1; cmd_src2 = 4'd0; cmd_dst2 = 4'd7; Data2 = 16'hBEEF;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    chk("w16_busy", busy2, 1'b1);
    chk("w16_bus", bus2_w, 16'hBEEF);
    @(negedge clk);
    chk("w16_done", done2, 1'b1);
    chk("w16_q", Q2, {16'hBEEF, 112'h0});
    @(negedge clk);
    chk("w16_bus_idle", bus2_w, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_xfer_engine.md
Name: bus_xfer_engine

Overview:
- Parametrised register-file/bus structure: NREGS registers of WIDTH bits share one tri-state bus.
- One driver per register, one for external Data, one for an internal temp register TMP.
- Successor to the fixed 3×8-bit load/move structure. Adds:
  - parametrised width and depth;
  - indexed src/dst addressing;
  - a valid/busy command handshake;
  - a multi-cycle SWAP through TMP;
  - illegal-command detection.
- Sits between the control sequencer and the datapath registers.

Parameters:
- WIDTH, 8, register, Data and bus width.
- NREGS, 4, number of registers (2..16).
- AW, 4, src/dst index width; must satisfy 2^AW >= NREGS.

Ports:
- Clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_op  input  2  0=NOP, 1=LOAD (Data->R[dst]), 2=MOVE (R[src]->R[dst]), 3=SWAP (R[src]<->R[dst])
- cmd_src  input  AW  source register index
- cmd_dst  input  AW  destination register index
- Data  input  WIDTH  external load value
- busy  output  1  command executing
- done  output  1  one-cycle pulse on completion
- err  output  1  one-cycle pulse on rejected command
- bus  output  WIDTH  shared tri-state bus; all-Z when undriven
- Q  output  NREGS*WIDTH  register contents; R[i] at Q[i*WIDTH +: WIDTH]

Behaviour:
- Reset (synchronous, takes priority over everything):
  - all R[i]=0, TMP=0, state=IDLE;
  - busy=0, done=0, err=0, bus=all-Z;
  - an operation in progress is abandoned, with no partial write after the reset edge.
- Bus drivers:
  - each driver is a tri-state buffer with its own enable;
  - at most one enable is high in any cycle;
  - in IDLE all enables are low and bus is all-Z.
- Acceptance:
  - a command is accepted on a rising edge where cmd_valid=1, busy=0 and state=IDLE;
  - cmd_valid while busy=1 is ignored; no queueing;
  - on acceptance, op/src/dst/Data are latched; later input changes do not affect the executing command.
- NOP: accepted with no effect; no done, no err.
- Rejection (err=1 for the cycle after the edge; no register change; busy stays 0). Rejected when any of:
  - dst>=NREGS for LOAD/MOVE/SWAP;
  - src>=NREGS for MOVE/SWAP;
  - src==dst for MOVE/SWAP.
  - src is ignored for LOAD.
- State machine: IDLE, XFER, SW1, SW2, SW3.
  - IDLE -> XFER for accepted LOAD/MOVE.
  - IDLE -> SW1 for accepted SWAP.
  - XFER -> IDLE.
  - SW1 -> SW2 -> SW3 -> IDLE.
- Per-state bus driver and write on the edge ending the state:
  - XFER: bus driven by latched Data (LOAD) or R[src] (MOVE); R[dst]<=bus.
  - SW1: bus=R[src]; TMP<=bus.
  - SW2: bus=R[dst]; R[src]<=bus.
  - SW3: bus=TMP; R[dst]<=bus.
- busy:
  - high in every non-IDLE state;
  - LOAD/MOVE: busy high for 1 cycle;
  - SWAP: busy high for 3 cycles.
- done:
  - registered; high for the one cycle after the final write edge;
  - busy=0 in that cycle, so a new command may be accepted on the edge that ends the done cycle.
- Latency: accept edge k; write edge k+1 (LOAD/MOVE) or k+3 (SWAP); done high in cycle k+1..k+2 or k+3..k+4.
- Q: continuously reflects the registers; no extra latency.
- Registers not addressed by the current command hold their value.

Test Plan:
- Reset: assert reset 2 cycles mid-SWAP -> all Q=0, bus=Z, busy=0, done=0; no write after the reset edge.
- Loads (WIDTH=8, NREGS=4): LOAD Data=0x01,0x02,0x03,0x04 to R0..R3 -> Q=0x04030201.
  - Each: busy high 1 cycle, bus=Data in XFER, done pulse after.
  - bus=Z between commands.
- MOVE: src=2, dst=0 -> R0=0x03, R2 unchanged; bus=0x03 during XFER.
  - Changing Data/cmd_src during XFER has no effect.
- SWAP: R1=0x02, R3=0x04, src=1, dst=3 -> bus sequence 0x02, 0x04, 0x02 over 3 cycles.
  - Then R1=0x04, R3=0x02; busy high exactly 3 cycles; one done pulse.
- Errors, each -> err pulse, no Q change, busy stays 0:
  - MOVE src=1 dst=1;
  - LOAD dst=4 (NREGS=4);
  - SWAP src=5.
- Handshake: hold cmd_valid with a new MOVE throughout a SWAP -> MOVE ignored while busy, accepted at the first edge with busy=0.
  - Also instantiate WIDTH=16, NREGS=8: LOAD 0xBEEF to R7 -> Q[127:112]=0xBEEF.
